branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Execute-stage branch resolution unit. Consumes the signed compare result (eq, lt) and the unsigned less-than from the operand comparators.
- Decides taken/not-taken for conditional branches and jumps, and computes the target. Issues a registered PC redirect plus a flush window that squashes wrong-path instructions.
- Static predict-not-taken front end, so every taken control transfer is a redirect.
- Keeps branch and redirect performance counters.

Parameters:
- XLEN, 32, data/address width.
- FLUSH_CYC, 2, number of advancing pipeline cycles squashed after a redirect (1..7).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_valid  in  1  EX-stage instruction valid
- i_stall  in  1  pipeline hold; EX contents do not advance
- i_is_branch  in  1  conditional branch (B-type)
- i_is_jal  in  1  JAL
- i_is_jalr  in  1  JALR
- i_funct3  in  3  branch condition code
- i_pc  in  XLEN  PC of EX instruction
- i_imm  in  XLEN  sign-extended immediate
- i_rs1  in  XLEN  rs1 operand (JALR base)
- i_eq  in  1  rs1 == rs2
- i_lt  in  1  signed rs1 < rs2
- i_ltu  in  1  unsigned rs1 < rs2
- o_redirect  out  1  one-cycle PC redirect pulse
- o_target  out  XLEN  redirect target, valid with o_redirect
- o_flush  out  1  squash IF/ID and ignore EX input
- o_misalign  out  1  one-cycle pulse: taken target bit1 set
- o_br_cnt  out  32  resolved control-flow instructions
- o_redir_cnt  out  32  redirects issued

Behaviour:
- One clock, i_clk. Reset is synchronous and active-low on i_rst_n. On reset, every output is 0, state is IDLE and the shadow counter is 0.
- Accept condition: acc = i_valid & ~i_stall & ~o_flush. At most one of i_is_branch, i_is_jal, i_is_jalr is set; if several are set, priority is jalr > jal > branch.
- Condition decode (i_funct3):
  - 000 taken=eq
  - 001 taken=~eq
  - 100 taken=lt
  - 101 taken=~lt
  - 110 taken=ltu
  - 111 taken=~ltu
  - 010/011 taken=0
- JAL and JALR are always taken.
- Target:
  - JALR: (i_rs1 + i_imm) & ~1.
  - Otherwise: i_pc + i_imm.
  - Arithmetic is modulo 2^XLEN; carry is discarded.
- Misaligned target: if a taken target has bit1 = 1, o_misalign pulses and no redirect is issued. o_br_cnt still increments; o_redir_cnt does not.
- Latency: outputs are registered. o_redirect, o_target and o_flush rise in the cycle after acceptance.
- FSM:
  - IDLE: on acc & control-flow & taken & aligned, go to SHADOW. Load cnt = FLUSH_CYC, and set o_redirect=1, o_flush=1, o_target.
  - SHADOW: o_redirect=0 after its first cycle; o_flush=1 throughout.
    - cnt decrements only on cycles with ~i_stall, because stalled cycles bring in no new wrong-path instruction.
    - When cnt reaches 1 and ~i_stall, go to IDLE with o_flush=0 in the next cycle.
    - i_valid is ignored throughout SHADOW.
- o_target holds its last value when o_redirect=0.
- Counters:
  - o_br_cnt increments on each accepted instruction with any control-flow flag set.
  - o_redir_cnt increments on each redirect.
  - Both wrap 0xFFFFFFFF -> 0.
- Stall in IDLE: no acceptance and no counter change. Inputs are re-evaluated each cycle.
- Reset mid-SHADOW aborts immediately: o_flush=0 next cycle, counters cleared.
- Non-control-flow valid instruction: no output change except that o_redirect/o_misalign fall to 0.

Test Plan:
- Reset then BEQ with i_eq=1, i_pc=0x100, i_imm=0x20 -> next cycle o_redirect=1, o_target=0x120, o_flush=1 for 2 cycles, o_br_cnt=1, o_redir_cnt=1.
- BLT with i_lt=0, then BGEU with i_ltu=1 -> no redirect, o_flush=0, o_br_cnt=2, o_redir_cnt=0.
- JALR with i_rs1=0x1003, i_imm=0x4 -> o_target=0x1006, with bit0 cleared; o_misalign=1 because bit1 is set; o_redirect=0.
- Taken BNE, then i_stall=1 for 3 cycles in SHADOW with i_valid=1 and a taken JAL presented -> o_flush stays high 5 cycles total; the JAL is ignored; o_redir_cnt=1.
- Taken JAL, and i_rst_n=0 in the first SHADOW cycle -> next cycle all outputs 0; a subsequent JAL is accepted normally.
- Preload via 0xFFFFFFFF taken jumps (or force) -> the next redirect wraps o_redir_cnt to 0. Also check i_pc=0xFFFFFFF0 with i_imm=0x20 gives o_target=0x10.

Source files
------------

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: decides taken/not-taken, computes the
// target, issues a registered redirect and a flush shadow, and counts
// resolved control transfers and redirects.
module branch_resolve #(
  parameter int XLEN      = 32,
  parameter int FLUSH_CYC = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic            i_stall,
  input  logic            i_is_branch,
  input  logic            i_is_jal,
  input  logic            i_is_jalr,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1,
  input  logic            i_eq,
  input  logic            i_lt,
  input  logic            i_ltu,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_target,
  output logic            o_flush,
  output logic            o_misalign,
  output logic [31:0]     o_br_cnt,
  output logic [31:0]     o_redir_cnt
);

  typedef enum logic {IDLE, SHADOW} state_t;

  localparam logic [XLEN-1:0] LSB_CLR = {{(XLEN-1){1'b1}}, 1'b0};
  localparam logic [2:0]      SHADOW_LEN = 3'(FLUSH_CYC);

  state_t          state, state_nxt;
  logic [2:0]      cnt, cnt_nxt;
  logic            cond, is_cf, taken, acc;
  logic            resolve, do_redir, do_mis;
  logic [XLEN-1:0] tgt;

  // Condition decode, target generation and the accept/redirect qualifiers
  always_comb begin
    cond = 1'b0;
    case (i_funct3)
      3'b000:  cond = i_eq;
      3'b001:  cond = ~i_eq;
      3'b100:  cond = i_lt;
      3'b101:  cond = ~i_lt;
      3'b110:  cond = i_ltu;
      3'b111:  cond = ~i_ltu;
      default: cond = 1'b0;
    endcase
    is_cf = i_is_branch | i_is_jal | i_is_jalr;
    // jalr > jal > branch; both jumps are unconditional
    taken = i_is_jalr | i_is_jal | (i_is_branch & cond);
    tgt   = i_is_jalr ? ((i_rs1 + i_imm) & LSB_CLR) : (i_pc + i_imm);
    // o_flush is high exactly while in SHADOW, so this also gates out SHADOW
    acc      = i_valid & ~i_stall & ~o_flush;
    resolve  = acc & is_cf & (state == IDLE);
    do_redir = resolve & taken & ~tgt[1];
    do_mis   = resolve & taken & tgt[1];
  end

  // Next-state logic: shadow length counts only advancing (unstalled) cycles
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (do_redir) begin
          state_nxt = SHADOW;
          cnt_nxt   = SHADOW_LEN;
        end
      end
      SHADOW: begin
        if (!i_stall) begin
          if (cnt <= 3'd1) begin
            state_nxt = IDLE;
            cnt_nxt   = 3'd0;
          end else begin
            cnt_nxt = cnt - 3'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // State, registered outputs and performance counters
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      o_redirect  <= 1'b0;
      o_target    <= '0;
      o_flush     <= 1'b0;
      o_misalign  <= 1'b0;
      o_br_cnt    <= 32'd0;
      o_redir_cnt <= 32'd0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      o_redirect  <= do_redir;
      o_misalign  <= do_mis;
      o_flush     <= (state_nxt == SHADOW);
      if (do_redir) o_target <= tgt;
      o_br_cnt    <= o_br_cnt + 32'(resolve);
      o_redir_cnt <= o_redir_cnt + 32'(do_redir);
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: a vector table for single-instruction
// resolution plus hand sequences for stall-in-shadow, reset-in-shadow and
// counter/target wrap.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, stall, is_br, is_jal, is_jalr;
  logic [2:0]  f3;
  logic [31:0] pc, imm, rs1;
  logic        eq, lt, ltu;
  logic        redirect, flush, misalign;
  logic [31:0] target, br_cnt, redir_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  branch_resolve #(.XLEN(32), .FLUSH_CYC(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall),
    .i_is_branch(is_br), .i_is_jal(is_jal), .i_is_jalr(is_jalr),
    .i_funct3(f3), .i_pc(pc), .i_imm(imm), .i_rs1(rs1),
    .i_eq(eq), .i_lt(lt), .i_ltu(ltu),
    .o_redirect(redirect), .o_target(target), .o_flush(flush),
    .o_misalign(misalign), .o_br_cnt(br_cnt), .o_redir_cnt(redir_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, stall, br, jal, jalr;
    logic [2:0]  f3;
    logic [31:0] pc, imm, rs1;
    logic        eq, lt, ltu;
    logic        e_rd, e_mis, chk_t;
    logic [31:0] e_tgt, e_br, e_rc;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    valid = 0; stall = 0; is_br = 0; is_jal = 0; is_jalr = 0;
    f3 = 0; pc = 0; imm = 0; rs1 = 0; eq = 0; lt = 0; ltu = 0;
  endtask

  task automatic drive(input vec_t v);
    valid = v.valid; stall = v.stall; is_br = v.br; is_jal = v.jal; is_jalr = v.jalr;
    f3 = v.f3; pc = v.pc; imm = v.imm; rs1 = v.rs1; eq = v.eq; lt = v.lt; ltu = v.ltu;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " redirect"}, 32'(redirect), 0);
    chk({tag, " target"},   target,        0);
    chk({tag, " flush"},    32'(flush),    0);
    chk({tag, " misalign"}, 32'(misalign), 0);
    chk({tag, " br_cnt"},   br_cnt,        0);
    chk({tag, " redir_cnt"}, redir_cnt,    0);
  endtask

  // Let a redirect's shadow run out with no instructions; flush stays high
  // for FLUSH_CYC advancing cycles in total.
  task automatic drain(input string tag);
    idle_in();
    step();
    chk({tag, " shadow flush"},    32'(flush),    1);
    chk({tag, " shadow redirect"}, 32'(redirect), 0);
    step();
    chk({tag, " flush end"}, 32'(flush), 0);
  endtask

  initial begin
    //            v st br jal jalr f3    pc            imm           rs1          eq lt ltu rd mis ct tgt           br  rc
    vecs[0]  = '{1,0, 1,0,0, 3'b000, 32'h100,      32'h20,       32'h0,       1,0,0, 1,0,1, 32'h120,      1, 1};
    vecs[1]  = '{1,0, 1,0,0, 3'b100, 32'h140,      32'h40,       32'h0,       0,0,0, 0,0,0, 32'h0,        2, 1};
    vecs[2]  = '{1,0, 1,0,0, 3'b111, 32'h144,      32'h40,       32'h0,       0,0,1, 0,0,0, 32'h0,        3, 1};
    vecs[3]  = '{1,0, 0,0,1, 3'b000, 32'h148,      32'h4,        32'h1003,    0,0,0, 0,1,0, 32'h0,        4, 1};
    vecs[4]  = '{1,0, 0,0,0, 3'b000, 32'h14c,      32'h10,       32'h0,       1,0,0, 0,0,0, 32'h0,        4, 1};
    vecs[5]  = '{1,1, 0,1,0, 3'b000, 32'h150,      32'h10,       32'h0,       0,0,0, 0,0,0, 32'h0,        4, 1};
    vecs[6]  = '{1,0, 1,0,0, 3'b010, 32'h154,      32'h10,       32'h0,       1,1,1, 0,0,0, 32'h0,        5, 1};
    vecs[7]  = '{1,0, 1,0,0, 3'b001, 32'h200,      32'hFFFFFFF8, 32'h0,       0,0,0, 1,0,1, 32'h1F8,      6, 2};
    vecs[8]  = '{1,0, 1,0,0, 3'b101, 32'h300,      32'h40,       32'h0,       0,0,0, 1,0,1, 32'h340,      7, 3};
    vecs[9]  = '{1,0, 1,0,0, 3'b110, 32'h400,      32'h10,       32'h0,       0,0,1, 1,0,1, 32'h410,      8, 4};
    vecs[10] = '{1,0, 0,1,0, 3'b000, 32'h500,      32'h100,      32'h0,       0,0,0, 1,0,1, 32'h600,      9, 5};
    vecs[11] = '{1,0, 1,1,1, 3'b011, 32'h10,       32'h10,       32'h2001,    0,0,0, 1,0,1, 32'h2010,    10, 6};
    vecs[12] = '{1,0, 1,0,0, 3'b000, 32'h600,      32'h10,       32'h0,       0,1,1, 0,0,0, 32'h0,       11, 6};
    vecs[13] = '{1,0, 1,0,0, 3'b100, 32'h700,      32'h8,        32'h0,       0,1,0, 1,0,1, 32'h708,     12, 7};
    vecs[14] = '{1,0, 1,0,0, 3'b000, 32'h800,      32'h6,        32'h0,       1,0,0, 0,1,0, 32'h0,       13, 7};
    vecs[15] = '{0,0, 1,0,0, 3'b000, 32'h900,      32'h10,       32'h0,       1,0,0, 0,0,0, 32'h0,       13, 7};

    idle_in();
    rst_n = 0;
    step(); step();
    chk_zero("reset");
    rst_n = 1;

    // Table: one instruction per vector, result checked one cycle later
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i]);
      step();
      chk($sformatf("v%0d redirect", i), 32'(redirect), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d misalign", i), 32'(misalign), 32'(vecs[i].e_mis));
      chk($sformatf("v%0d flush", i),    32'(flush),    32'(vecs[i].e_rd));
      chk($sformatf("v%0d br_cnt", i),   br_cnt,        vecs[i].e_br);
      chk($sformatf("v%0d redir_cnt", i), redir_cnt,    vecs[i].e_rc);
      if (vecs[i].chk_t) chk($sformatf("v%0d target", i), target, vecs[i].e_tgt);
      if (vecs[i].e_rd) drain($sformatf("v%0d", i));
    end
    idle_in();
    step();
    chk("pulse falls misalign", 32'(misalign), 0);
    chk("target holds", target, 32'h708);

    // Stall inside the shadow with a taken JAL presented: shadow stretches
    // to 5 cycles and the JAL is never accepted.
    valid = 1; is_br = 1; f3 = 3'b001; eq = 0; pc = 32'hA00; imm = 32'h40;
    step();
    chk("stl redirect", 32'(redirect), 1);
    chk("stl target", target, 32'hA40);
    idle_in();
    valid = 1; stall = 1; is_jal = 1; pc = 32'hB00; imm = 32'h80;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stl flush s%0d", k), 32'(flush), 1);
      chk($sformatf("stl redirect s%0d", k), 32'(redirect), 0);
    end
    stall = 0;
    step();
    chk("stl flush adv", 32'(flush), 1);
    step();
    chk("stl flush end", 32'(flush), 0);
    chk("stl jal ignored", 32'(redirect), 0);
    idle_in();
    chk("stl br_cnt", br_cnt, 14);
    chk("stl redir_cnt", redir_cnt, 8);
    step();
    chk("stl quiet redirect", 32'(redirect), 0);

    // Reset in the first shadow cycle aborts everything
    valid = 1; is_jal = 1; pc = 32'hC00; imm = 32'h20;
    step();
    chk("rst jal redirect", 32'(redirect), 1);
    idle_in();
    rst_n = 0;
    step();
    chk_zero("rst mid-shadow");
    rst_n = 1;
    valid = 1; is_jal = 1; pc = 32'h40; imm = 32'h10;
    step();
    chk("post-rst redirect", 32'(redirect), 1);
    chk("post-rst target", target, 32'h50);
    chk("post-rst br_cnt", br_cnt, 1);
    chk("post-rst redir_cnt", redir_cnt, 1);
    drain("post-rst");

    // Counter wrap and target wrap: preload counters at all-ones across an
    // idle edge, then one taken branch whose target wraps past 2^32.
    idle_in();
    force dut.o_br_cnt    = 32'hFFFFFFFF;
    force dut.o_redir_cnt = 32'hFFFFFFFF;
    step();
    release dut.o_br_cnt;
    release dut.o_redir_cnt;
    step();
    chk("preload redir_cnt", redir_cnt, 32'hFFFFFFFF);
    valid = 1; is_br = 1; f3 = 3'b000; eq = 1; pc = 32'hFFFFFFF0; imm = 32'h20;
    step();
    chk("wrap redirect", 32'(redirect), 1);
    chk("wrap target", target, 32'h10);
    chk("wrap redir_cnt", redir_cnt, 0);
    chk("wrap br_cnt", br_cnt, 0);
    drain("wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
